sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arb_pkg.sv | 20 ++
 rtl/sdram_arb_tag_fifo.sv | 64 ++++++
 rtl/sdram_arbiter.sv | 176 +++++++++++++++++
 tb/tb_sdram_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-master SDRAM arbiter.
// Port IDs double as the read-return tag stored in the tag FIFO.
package sdram_arb_pkg;

    localparam int ADDR_W_DEF = 25;
    localparam int DATA_W     = 16;
    localparam int BE_W       = DATA_W / 8;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_id_t;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        HOLD_A = 2'd1,
        HOLD_B = 2'd2
    } arb_state_t;

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// Read-return tag FIFO: remembers which port issued each outstanding read.
// Head is visible combinationally so the return can be routed in the same cycle.
module sdram_arb_tag_fifo
    import sdram_arb_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  port_id_t         push_id,
    input  logic             pop,
    output port_id_t         head,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    port_id_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset: an empty count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/sdram_arbiter.sv
// Two-master Avalon-MM arbiter in front of an SDRAM controller: port A (audio)
// has priority, port B is protected from starvation, read returns are tag-routed.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int MAX_PENDING  = 8,
    parameter int STARVE_LIMIT = 16
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,

    input  logic [ADDR_W-1:0] a_address,
    input  logic              a_read,
    input  logic              a_write,
    input  logic [DATA_W-1:0] a_writedata,
    input  logic [BE_W-1:0]   a_byteenable,
    output logic              a_waitrequest,
    output logic [DATA_W-1:0] a_readdata,
    output logic              a_readdatavalid,

    input  logic [ADDR_W-1:0] b_address,
    input  logic              b_read,
    input  logic              b_write,
    input  logic [DATA_W-1:0] b_writedata,
    input  logic [BE_W-1:0]   b_byteenable,
    output logic              b_waitrequest,
    output logic [DATA_W-1:0] b_readdata,
    output logic              b_readdatavalid,

    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    output logic              m_write,
    output logic [DATA_W-1:0] m_writedata,
    output logic [BE_W-1:0]   m_byteenable,
    input  logic              m_waitrequest,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_readdatavalid,

    output logic              err_orphan
);

    localparam int CNT_W = $clog2(MAX_PENDING + 1);
    localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

    arb_state_t       state_q;
    logic [ST_W-1:0]  starve_q;
    logic [ST_W-1:0]  starve_d;
    logic             err_orphan_q;

    logic             read_room;
    logic             elig_a;
    logic             elig_b;
    logic             gnt_valid;
    port_id_t         gnt_id;
    logic             accept;
    logic             push;
    logic             pop;
    logic             orphan;
    port_id_t         fifo_head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             fifo_full;

    // Uses the registered count, so a pop in this cycle cannot unblock a read.
    assign read_room = (fifo_count < CNT_W'(MAX_PENDING));
    assign elig_a    = a_write || (a_read && read_room);
    assign elig_b    = b_write || (b_read && read_room);

    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = PORT_A;
        case (state_q)
            HOLD_A: begin
                gnt_valid = 1'b1;
                gnt_id    = PORT_A;
            end
            HOLD_B: begin
                gnt_valid = 1'b1;
                gnt_id    = PORT_B;
            end
            default: begin
                if (elig_a && (starve_q < ST_W'(STARVE_LIMIT))) begin
                    gnt_valid = 1'b1;
                    gnt_id    = PORT_A;
                end else if (elig_b) begin
                    gnt_valid = 1'b1;
                    gnt_id    = PORT_B;
                end
            end
        endcase
        if (!reset_reset_n) begin
            gnt_valid = 1'b0;
        end
    end

    always_comb begin
        if (gnt_id == PORT_B) begin
            m_address    = b_address;
            m_writedata  = b_writedata;
            m_byteenable = b_byteenable;
            m_read       = gnt_valid && b_read;
            m_write      = gnt_valid && b_write;
        end else begin
            m_address    = a_address;
            m_writedata  = a_writedata;
            m_byteenable = a_byteenable;
            m_read       = gnt_valid && a_read;
            m_write      = gnt_valid && a_write;
        end
    end

    assign a_waitrequest = !(gnt_valid && gnt_id == PORT_A) || m_waitrequest;
    assign b_waitrequest = !(gnt_valid && gnt_id == PORT_B) || m_waitrequest;

    assign accept = (m_read || m_write) && !m_waitrequest;
    assign push   = accept && m_read;
    assign pop    = m_readdatavalid && !fifo_empty;
    assign orphan = m_readdatavalid && fifo_empty;

    assign a_readdatavalid = pop && (fifo_head == PORT_A);
    assign b_readdatavalid = pop && (fifo_head == PORT_B);
    assign a_readdata      = m_readdata;
    assign b_readdata      = m_readdata;
    assign err_orphan      = err_orphan_q;

    always_comb begin
        starve_d = starve_q;
        if (accept && gnt_id == PORT_B) begin
            starve_d = '0;
        end else if (elig_b && starve_q != ST_W'(STARVE_LIMIT)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q      <= ARB;
            starve_q     <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            starve_q <= starve_d;
            if (orphan) begin
                err_orphan_q <= 1'b1;
            end
            case (state_q)
                ARB: begin
                    if ((m_read || m_write) && m_waitrequest) begin
                        state_q <= (gnt_id == PORT_B) ? HOLD_B : HOLD_A;
                    end
                end
                HOLD_A, HOLD_B: begin
                    if (!m_waitrequest) begin
                        state_q <= ARB;
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

    sdram_arb_tag_fifo #(
        .DEPTH (MAX_PENDING)
    ) u_tag_fifo (
        .clk     (clk_clk),
        .rst_n   (reset_reset_n),
        .push    (push),
        .push_id (gnt_id),
        .pop     (pop),
        .head    (fifo_head),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: priority/starvation, hold, read blocking,
// tag routing, orphan returns and asynchronous reset.
module tb_sdram_arbiter;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic [24:0] a_address, b_address, m_address;
    logic        a_read, a_write, b_read, b_write, m_read, m_write;
    logic [15:0] a_writedata, b_writedata, m_writedata;
    logic [1:0]  a_byteenable, b_byteenable, m_byteenable;
    logic        a_waitrequest, b_waitrequest, m_waitrequest;
    logic [15:0] a_readdata, b_readdata, m_readdata;
    logic        a_readdatavalid, b_readdatavalid, m_readdatavalid;
    logic        err_orphan;

    int n_compared   = 0;
    int n_mismatched = 0;

    localparam logic [24:0] ADDR_A = 25'h0000100;
    localparam logic [24:0] ADDR_B = 25'h0001234;

    always #5 clk_clk = ~clk_clk;

    sdram_arbiter dut (
        .clk_clk         (clk_clk),
        .reset_reset_n   (reset_reset_n),
        .a_address       (a_address),
        .a_read          (a_read),
        .a_write         (a_write),
        .a_writedata     (a_writedata),
        .a_byteenable    (a_byteenable),
        .a_waitrequest   (a_waitrequest),
        .a_readdata      (a_readdata),
        .a_readdatavalid (a_readdatavalid),
        .b_address       (b_address),
        .b_read          (b_read),
        .b_write         (b_write),
        .b_writedata     (b_writedata),
        .b_byteenable    (b_byteenable),
        .b_waitrequest   (b_waitrequest),
        .b_readdata      (b_readdata),
        .b_readdatavalid (b_readdatavalid),
        .m_address       (m_address),
        .m_read          (m_read),
        .m_write         (m_write),
        .m_writedata     (m_writedata),
        .m_byteenable    (m_byteenable),
        .m_waitrequest   (m_waitrequest),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .err_orphan      (err_orphan)
    );

    always @(negedge clk_clk) begin
        if (reset_reset_n && (m_read || m_write) && !m_waitrequest) begin
            $display("xfer %s addr=%07h a_wait=%0b b_wait=%0b", m_read ? "RD" : "WR",
                     m_address, a_waitrequest, b_waitrequest);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_read = 0; a_write = 0; b_read = 0; b_write = 0;
        m_waitrequest = 0; m_readdatavalid = 0; m_readdata = '0;
    endtask

    task automatic drain_one_a();
        idle_inputs();
        m_readdatavalid = 1;
        #3;
        check_eq("drain_a_rdv", 32'(a_readdatavalid), 1);
        check_eq("drain_b_rdv", 32'(b_readdatavalid), 0);
        tick();
        m_readdatavalid = 0;
    endtask

    initial begin
        port_tag_t_dummy: begin end
        reset_reset_n = 0;
        a_address = ADDR_A; b_address = ADDR_B;
        a_writedata = 16'hAAAA; b_writedata = 16'hBBBB;
        a_byteenable = 2'b11; b_byteenable = 2'b11;
        idle_inputs();
        a_write = 1;
        #2;
        check_eq("rst_a_wait", 32'(a_waitrequest), 1);
        check_eq("rst_b_wait", 32'(b_waitrequest), 1);
        check_eq("rst_m_write", 32'(m_write), 0);
        check_eq("rst_m_read", 32'(m_read), 0);
        check_eq("rst_err", 32'(err_orphan), 0);
        tick();
        tick();
        a_write = 0;
        reset_reset_n = 1;

        // Both ports read every cycle: A wins 16 times, then B once.
        a_read = 1; b_read = 1;
        for (int cyc = 1; cyc <= 18; cyc++) begin
            logic exp_b;
            exp_b = (cyc == 17);
            m_readdatavalid = (cyc > 1);
            #3;
            check_eq($sformatf("starve_a_wait_c%0d", cyc), 32'(a_waitrequest), 32'(exp_b));
            check_eq($sformatf("starve_b_wait_c%0d", cyc), 32'(b_waitrequest), 32'(!exp_b));
            check_eq($sformatf("starve_addr_c%0d", cyc), 32'(m_address), exp_b ? 32'(ADDR_B) : 32'(ADDR_A));
            check_eq($sformatf("starve_a_rdv_c%0d", cyc), 32'(a_readdatavalid), 32'(cyc > 1 && cyc < 18));
            check_eq($sformatf("starve_b_rdv_c%0d", cyc), 32'(b_readdatavalid), 32'(cyc == 18));
            if (cyc == 17) check_eq("starve_cnt_full", 32'(dut.starve_q), 16);
            if (cyc == 18) check_eq("starve_cnt_clear", 32'(dut.starve_q), 0);
            tick();
        end
        drain_one_a();
        check_eq("starve_fifo_empty", 32'(dut.fifo_count), 0);

        // B write held off by the controller for 5 cycles while A requests.
        for (int cyc = 1; cyc <= 7; cyc++) begin
            idle_inputs();
            b_write = (cyc <= 6);
            a_read = (cyc >= 2);
            m_waitrequest = (cyc <= 5);
            #3;
            if (cyc <= 6) begin
                check_eq($sformatf("hold_addr_c%0d", cyc), 32'(m_address), 32'(ADDR_B));
                check_eq($sformatf("hold_a_wait_c%0d", cyc), 32'(a_waitrequest), 1);
                check_eq($sformatf("hold_b_wait_c%0d", cyc), 32'(b_waitrequest), 32'(cyc <= 5));
                check_eq($sformatf("hold_data_c%0d", cyc), 32'(m_writedata), 32'h0000BBBB);
            end else begin
                check_eq("hold_back_arb", 32'(dut.state_q), 0);
                check_eq("hold_a_granted", 32'(a_waitrequest), 0);
            end
            if (cyc >= 2 && cyc <= 6) check_eq($sformatf("hold_state_c%0d", cyc), 32'(dut.state_q), 2);
            tick();
        end
        drain_one_a();

        // Fill the tag FIFO with A reads; the 9th must stall, a B write still passes.
        idle_inputs();
        for (int cyc = 1; cyc <= 11; cyc++) begin
            a_read = 1;
            b_write = (cyc == 9);
            m_readdatavalid = (cyc == 10);
            #3;
            check_eq($sformatf("full_a_wait_c%0d", cyc), 32'(a_waitrequest), 32'(cyc == 9 || cyc == 10));
            if (cyc == 9) begin
                check_eq("full_b_write_wait", 32'(b_waitrequest), 0);
                check_eq("full_m_write", 32'(m_write), 1);
                check_eq("full_m_read", 32'(m_read), 0);
            end
            if (cyc == 10) check_eq("full_pop_rdv", 32'(a_readdatavalid), 1);
            tick();
        end
        check_eq("full_count", 32'(dut.fifo_count), 8);
        for (int i = 0; i < 8; i++) drain_one_a();

        // Interleaved reads A,B,B,A, then returns carrying 0x1111..0x4444.
        begin
            logic [3:0] order;
            order = 4'b0110;
            for (int i = 0; i < 4; i++) begin
                idle_inputs();
                a_read = !order[i];
                b_read = order[i];
                #3;
                check_eq($sformatf("ilv_accept_%0d", i), 32'(order[i] ? b_waitrequest : a_waitrequest), 0);
                tick();
            end
            idle_inputs();
            for (int i = 0; i < 4; i++) begin
                m_readdatavalid = 1;
                m_readdata = 16'(16'h1111 * (i + 1));
                #3;
                check_eq($sformatf("ilv_a_rdv_%0d", i), 32'(a_readdatavalid), 32'(!order[i]));
                check_eq($sformatf("ilv_b_rdv_%0d", i), 32'(b_readdatavalid), 32'(order[i]));
                check_eq($sformatf("ilv_data_%0d", i), 32'(order[i] ? b_readdata : a_readdata), 32'(16'h1111 * (i + 1)));
                tick();
            end
            m_readdatavalid = 0;
        end

        // Return with nothing outstanding.
        idle_inputs();
        m_readdatavalid = 1;
        #3;
        check_eq("orphan_a_rdv", 32'(a_readdatavalid), 0);
        check_eq("orphan_b_rdv", 32'(b_readdatavalid), 0);
        check_eq("orphan_err_before", 32'(err_orphan), 0);
        tick();
        m_readdatavalid = 0;
        for (int i = 0; i < 3; i++) begin
            #3;
            check_eq($sformatf("orphan_err_sticky_%0d", i), 32'(err_orphan), 1);
            tick();
        end
        check_eq("orphan_no_pop", 32'(dut.fifo_count), 0);

        // Reset in the middle of HOLD_B with three reads pending.
        idle_inputs();
        a_read = 1;
        for (int i = 0; i < 3; i++) tick();
        idle_inputs();
        b_write = 1;
        m_waitrequest = 1;
        tick();
        #3;
        check_eq("rst_mid_state", 32'(dut.state_q), 2);
        check_eq("rst_mid_count", 32'(dut.fifo_count), 3);
        check_eq("rst_mid_m_write", 32'(m_write), 1);
        reset_reset_n = 0;
        #1;
        check_eq("rst_async_m_write", 32'(m_write), 0);
        check_eq("rst_async_b_wait", 32'(b_waitrequest), 1);
        check_eq("rst_async_a_wait", 32'(a_waitrequest), 1);
        check_eq("rst_async_state", 32'(dut.state_q), 0);
        check_eq("rst_async_count", 32'(dut.fifo_count), 0);
        check_eq("rst_async_err", 32'(err_orphan), 0);
        tick();
        idle_inputs();
        reset_reset_n = 1;
        m_readdatavalid = 1;
        #3;
        check_eq("rst_late_a_rdv", 32'(a_readdatavalid), 0);
        check_eq("rst_late_b_rdv", 32'(b_readdatavalid), 0);
        tick();
        m_readdatavalid = 0;
        #3;
        check_eq("rst_late_err", 32'(err_orphan), 1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
